// File: rtl/lsu_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_stage_pkg
//  Description : Shared encodings for the LSU memory stage: RV64 load funct3
//                codes, access-size codes (funct3[1:0]), FSM state encoding
//                and the byte-lane mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_mem_stage_pkg;

    // Load funct3 encodings (bit 2 selects zero-extension)
    localparam logic [2:0] c_F3_LB     = 3'b000;
    localparam logic [2:0] c_F3_LH     = 3'b001;
    localparam logic [2:0] c_F3_LW     = 3'b010;
    localparam logic [2:0] c_F3_LD     = 3'b011;
    localparam logic [2:0] c_F3_LBU    = 3'b100;
    localparam logic [2:0] c_F3_LHU    = 3'b101;
    localparam logic [2:0] c_F3_LWU    = 3'b110;
    localparam logic [2:0] c_F3_LD_ILL = 3'b111;

    // Access size as carried in funct3[1:0] (SB..SD share these codes)
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;
    localparam logic [1:0] c_SZ_W = 2'b10;
    localparam logic [1:0] c_SZ_D = 2'b11;

    // LSU state encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // Byte-enable pattern for an access of the given size at lane 0
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        case (size)
            c_SZ_B:  return 8'h01;
            c_SZ_H:  return 8'h03;
            c_SZ_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_stage_align
//  Description : Combinational byte-lane logic for the LSU.
//                Load side : extract byte/half/word/dword at ld_off and
//                            sign- or zero-extend it.
//                Store side: shift store data to its lane, build strobes and
//                            decode misaligned / illegal accesses.
//  Ports       : load_i, store_i, funct3_i, off_i, sdata_i -> st_data_o,
//                st_strb_o, fault_o  (live EX-side access)
//                ld_funct3_i, ld_off_i, rdata_i -> ld_data_o (held load)
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage_align
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STRB_W = 8
) (
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic [2:0]        ld_funct3_i,
    input  logic [2:0]        ld_off_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   ld_data_o,
    output logic [XLEN-1:0]   st_data_o,
    output logic [STRB_W-1:0] st_strb_o,
    output logic              fault_o
);

    logic [XLEN-1:0] w_shifted;
    logic            w_misalign;

    // Load: bring the addressed bytes down to bit 0, then extend
    always_comb begin
        w_shifted = rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = '0;
        case (ld_funct3_i)
            c_F3_LB:  ld_data_o = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            c_F3_LH:  ld_data_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            c_F3_LW:  ld_data_o = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            c_F3_LD:  ld_data_o = w_shifted;
            c_F3_LBU: ld_data_o = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            c_F3_LHU: ld_data_o = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            c_F3_LWU: ld_data_o = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default:  ld_data_o = '0;
        endcase
    end

    // Store lane placement
    always_comb begin
        st_data_o = sdata_i << {off_i, 3'b000};
        st_strb_o = STRB_W'(lane_mask(funct3_i[1:0])) << off_i;
    end

    // Natural alignment required for every size
    always_comb begin
        w_misalign = 1'b0;
        case (funct3_i[1:0])
            c_SZ_H:  w_misalign = off_i[0];
            c_SZ_W:  w_misalign = |off_i[1:0];
            c_SZ_D:  w_misalign = |off_i;
            default: w_misalign = 1'b0;
        endcase
        fault_o = (load_i & store_i)
                | (load_i & (funct3_i == c_F3_LD_ILL))
                | (store_i & funct3_i[2])
                | ((load_i | store_i) & w_misalign);
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_stage
//  Description : Memory stage after EX. Passes ALU results to WB with one
//                cycle latency, performs loads/stores over a single-
//                outstanding req/ack port and reports misaligned/illegal
//                accesses as a one-cycle fault with valid_o.
//  Ports       : EX side  valid_i load_i store_i funct3_i sdata_i aluout_i
//                         rf_wen_i rd_i pc_i exit_i ; busy_o (stall)
//                Memory   dmem_req_o dmem_we_o dmem_addr_o dmem_wdata_o
//                         dmem_wstrb_o ; dmem_ack_i dmem_rdata_i
//                WB       valid_o rf_wen_o rd_o wdata_o pc_o exit_o fault_o
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic [XLEN-1:0]   aluout_i,
    input  logic              rf_wen_i,
    input  logic [4:0]        rd_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              exit_i,
    output logic              busy_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [STRB_W-1:0] dmem_wstrb_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              valid_o,
    output logic              rf_wen_o,
    output logic [4:0]        rd_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              exit_o,
    output logic              fault_o
);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    // Operation held for the duration of a memory access
    logic [XLEN-1:0]   r_addr;
    logic              r_we;
    logic [XLEN-1:0]   r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [2:0]        r_funct3;
    logic              r_load;
    logic              r_rf_wen;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_pc;
    logic              r_exit;

    // Writeback register
    logic              r_wb_valid;
    logic              r_wb_rf_wen;
    logic [4:0]        r_wb_rd;
    logic [XLEN-1:0]   r_wb_wdata;
    logic [XLEN-1:0]   r_wb_pc;
    logic              r_wb_exit;
    logic              r_wb_fault;

    logic [XLEN-1:0]   w_ld_data;
    logic [XLEN-1:0]   w_st_data;
    logic [STRB_W-1:0] w_st_strb;
    logic              w_fault;
    logic              w_mem_op;

    assign w_mem_op = load_i | store_i;

    lsu_mem_stage_align #(
        .XLEN   (XLEN),
        .STRB_W (STRB_W)
    ) u_align (
        .load_i      (load_i),
        .store_i     (store_i),
        .funct3_i    (funct3_i),
        .off_i       (aluout_i[2:0]),
        .sdata_i     (sdata_i),
        .ld_funct3_i (r_funct3),
        .ld_off_i    (r_addr[2:0]),
        .rdata_i     (dmem_rdata_i),
        .ld_data_o   (w_ld_data),
        .st_data_o   (w_st_data),
        .st_strb_o   (w_st_strb),
        .fault_o     (w_fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (valid_i && w_mem_op && !w_fault) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (dmem_ack_i) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_funct3    <= '0;
            r_load      <= 1'b0;
            r_rf_wen    <= 1'b0;
            r_rd        <= '0;
            r_pc        <= '0;
            r_exit      <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rf_wen <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_wdata  <= '0;
            r_wb_pc     <= '0;
            r_wb_exit   <= 1'b0;
            r_wb_fault  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_fault <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (valid_i && w_mem_op && !w_fault) begin
                    r_addr   <= aluout_i;
                    r_we     <= store_i;
                    r_wdata  <= store_i ? w_st_data : '0;
                    r_wstrb  <= store_i ? w_st_strb : '0;
                    r_funct3 <= funct3_i;
                    r_load   <= load_i;
                    r_rf_wen <= rf_wen_i;
                    r_rd     <= rd_i;
                    r_pc     <= pc_i;
                    r_exit   <= exit_i;
                end else if (valid_i) begin
                    // ALU result, or a faulting access retired without touching memory
                    r_wb_valid  <= 1'b1;
                    r_wb_fault  <= w_fault;
                    r_wb_rf_wen <= rf_wen_i & ~w_fault;
                    r_wb_rd     <= rd_i;
                    r_wb_wdata  <= w_fault ? '0 : aluout_i;
                    r_wb_pc     <= pc_i;
                    r_wb_exit   <= exit_i;
                end
            end else if (dmem_ack_i) begin
                r_wb_valid  <= 1'b1;
                r_wb_rf_wen <= r_rf_wen & r_load;
                r_wb_rd     <= r_rd;
                r_wb_wdata  <= r_load ? w_ld_data : '0;
                r_wb_pc     <= r_pc;
                r_wb_exit   <= r_exit;
            end
        end
    end

    assign busy_o       = (r_state == c_ST_BUSY);
    assign dmem_req_o   = (r_state == c_ST_BUSY);
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = {r_addr[XLEN-1:3], 3'b000};
    assign dmem_wdata_o = r_wdata;
    assign dmem_wstrb_o = r_wstrb;

    assign valid_o  = r_wb_valid;
    assign rf_wen_o = r_wb_rf_wen;
    assign rd_o     = r_wb_rd;
    assign wdata_o  = r_wb_wdata;
    assign pc_o     = r_wb_pc;
    assign exit_o   = r_wb_exit;
    assign fault_o  = r_wb_fault;

endmodule
`default_nettype wire
